jvs_feature_parser: RTL

- Parses the payload of a JVS feature-check (0x14) response into per-node capability fields.
- Sits between the JVS response framer, which delivers payload bytes after the status/report bytes, and the node-info store, which writes the fields into the node-info record at node_idx when done pulses.
- Handles 4-byte function records {code, p1, p2, p3}, terminated by code 0x00.

---
 rtl/jvs_feature_parser_if.sv | 9 +
 rtl/jvs_feature_parser.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jvs_feature_parser_if.sv
// Payload byte stream from the JVS response framer into the feature parser.
interface jvs_feature_parser_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_valid, in_data, in_last);
  modport slave  (input  in_valid, in_data, in_last);
endinterface

// File: rtl/jvs_feature_parser.sv
// Parses a JVS feature-check (0x14) payload of {code,p1,p2,p3} records into
// per-node capability fields; done pulses once the fields are final.
module jvs_feature_parser #(
  parameter int MAX_JVS_NODES = 2,
  parameter int MAX_RECORDS   = 16,
  localparam int NW = (MAX_JVS_NODES > 1) ? $clog2(MAX_JVS_NODES) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NW-1:0]        start_node,
  jvs_feature_parser_if.slave  payload,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 unk,
  output logic [NW-1:0]        node_idx,
  output logic [3:0]           players,
  output logic [3:0]           coin_slots,
  output logic [3:0]           analog_channels,
  output logic [3:0]           rotary_channels,
  output logic [3:0]           analog_output_channels,
  output logic [7:0]           buttons,
  output logic [7:0]           analog_bits,
  output logic [7:0]           screen_pos_x_bits,
  output logic [7:0]           screen_pos_y_bits,
  output logic [7:0]           screen_pos_channels,
  output logic [7:0]           digital_outputs,
  output logic [7:0]           card_system_slots,
  output logic [7:0]           medal_hopper_channels,
  output logic [7:0]           char_display_width,
  output logic [7:0]           char_display_height,
  output logic [7:0]           char_display_type,
  output logic [15:0]          misc_digital_inputs,
  output logic                 has_keycode_input,
  output logic                 has_screen_pos,
  output logic                 has_char_display,
  output logic                 has_backup
);

  localparam int CW = $clog2(MAX_RECORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CODE,
    P1,
    P2,
    P3
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [7:0]    code_reg;
  logic [7:0]    p1_reg;
  logic [7:0]    p2_reg;

  logic latch_code;
  logic latch_p1;
  logic latch_p2;
  logic decode_en;
  logic finish;
  logic fail;

  // Counts are 4-bit fields; larger reported values clamp to 15.
  function automatic logic [3:0] sat4(input logic [7:0] v);
    return (v > 8'd15) ? 4'hF : v[3:0];
  endfunction

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    latch_code = 1'b0;
    latch_p1   = 1'b0;
    latch_p2   = 1'b0;
    decode_en  = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;

    if (start) begin
      state_next = CODE;
      count_next = '0;
    end else if (payload.in_valid) begin
      case (state_reg)
        IDLE: begin
        end
        CODE: begin
          if (payload.in_data == 8'h00) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else if (payload.in_last) begin
            state_next = IDLE;
            finish     = 1'b1;
            fail       = 1'b1;
          end else begin
            latch_code = 1'b1;
            state_next = P1;
          end
        end
        P1: begin
          if (payload.in_last) begin
            state_next = IDLE;
            finish     = 1'b1;
            fail       = 1'b1;
          end else begin
            latch_p1   = 1'b1;
            state_next = P2;
          end
        end
        P2: begin
          if (payload.in_last) begin
            state_next = IDLE;
            finish     = 1'b1;
            fail       = 1'b1;
          end else begin
            latch_p2   = 1'b1;
            state_next = P3;
          end
        end
        P3: begin
          // A completed record is always decoded, even when it ends the parse.
          decode_en  = 1'b1;
          count_next = count_reg + CW'(1);
          if (payload.in_last || (count_reg == CW'(MAX_RECORDS - 1))) begin
            state_next = IDLE;
            finish     = 1'b1;
            fail       = 1'b1;
          end else begin
            state_next = CODE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      code_reg  <= '0;
      p1_reg    <= '0;
      p2_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (latch_code) code_reg <= payload.in_data;
      if (latch_p1)   p1_reg   <= payload.in_data;
      if (latch_p2)   p2_reg   <= payload.in_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy                   <= 1'b0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      unk                    <= 1'b0;
      node_idx               <= '0;
      players                <= '0;
      coin_slots             <= '0;
      analog_channels        <= '0;
      rotary_channels        <= '0;
      analog_output_channels <= '0;
      buttons                <= '0;
      analog_bits            <= '0;
      screen_pos_x_bits      <= '0;
      screen_pos_y_bits      <= '0;
      screen_pos_channels    <= '0;
      digital_outputs        <= '0;
      card_system_slots      <= '0;
      medal_hopper_channels  <= '0;
      char_display_width     <= '0;
      char_display_height    <= '0;
      char_display_type      <= '0;
      misc_digital_inputs    <= '0;
      has_keycode_input      <= 1'b0;
      has_screen_pos         <= 1'b0;
      has_char_display       <= 1'b0;
      has_backup             <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= finish;
      if (start) begin
        err                    <= 1'b0;
        unk                    <= 1'b0;
        node_idx               <= start_node;
        players                <= '0;
        coin_slots             <= '0;
        analog_channels        <= '0;
        rotary_channels        <= '0;
        analog_output_channels <= '0;
        buttons                <= '0;
        analog_bits            <= '0;
        screen_pos_x_bits      <= '0;
        screen_pos_y_bits      <= '0;
        screen_pos_channels    <= '0;
        digital_outputs        <= '0;
        card_system_slots      <= '0;
        medal_hopper_channels  <= '0;
        char_display_width     <= '0;
        char_display_height    <= '0;
        char_display_type      <= '0;
        misc_digital_inputs    <= '0;
        has_keycode_input      <= 1'b0;
        has_screen_pos         <= 1'b0;
        has_char_display       <= 1'b0;
        has_backup             <= 1'b0;
      end else begin
        if (finish) err <= fail;
        // p3 is the byte on the bus right now; later duplicates overwrite.
        if (decode_en) begin
          case (code_reg)
            8'h01: begin
              players <= sat4(p1_reg);
              buttons <= p2_reg;
            end
            8'h02: coin_slots <= sat4(p1_reg);
            8'h03: begin
              analog_channels <= sat4(p1_reg);
              analog_bits     <= p2_reg;
            end
            8'h04: rotary_channels <= sat4(p1_reg);
            8'h05: has_keycode_input <= 1'b1;
            8'h06: begin
              has_screen_pos      <= 1'b1;
              screen_pos_x_bits   <= p1_reg;
              screen_pos_y_bits   <= p2_reg;
              screen_pos_channels <= payload.in_data;
            end
            8'h07: misc_digital_inputs <= {p1_reg, p2_reg};
            8'h10: card_system_slots <= p1_reg;
            8'h11: medal_hopper_channels <= p1_reg;
            8'h12: digital_outputs <= p1_reg;
            8'h13: analog_output_channels <= sat4(p1_reg);
            8'h14: begin
              has_char_display    <= 1'b1;
              char_display_width  <= p1_reg;
              char_display_height <= p2_reg;
              char_display_type   <= payload.in_data;
            end
            8'h15: has_backup <= 1'b1;
            default: unk <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule
